param_input_buffer: RTL and testbench

PARAM_INPUT_BUFFER -- requirements
Module: param_input_buffer

---
 rtl/param_input_buffer.sv | 96 +++++++++
 tb/tb_param_input_buffer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/param_input_buffer.sv
// First-word-fall-through input buffer with occupancy count, registered almost_full
// and a sticky flag for pushes lost to a flush.
module param_input_buffer #(
  parameter int WIDTH     = 131,
  parameter int DEPTH     = 32,
  parameter int AFULL_LVL = 28
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       almost_full,
  output logic                       push_drop
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_LVL);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("param_input_buffer: DEPTH must be a power of two, at least 2");
  end
  if ((AFULL_LVL < 1) || (AFULL_LVL > DEPTH)) begin : g_bad_afull
    $error("param_input_buffer: AFULL_LVL must lie in 1..DEPTH");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_nxt;
  logic             push;
  logic             pop;

  // Ready looks only at registered occupancy and flush, so a full buffer never
  // accepts a packet even when the consumer pops in the same cycle.
  assign in_ready  = (count != FULL_CNT) && !flush;
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !flush;
  assign out_data  = mem[rd_ptr];

  always_comb begin
    // NOTE: default first so every path assigns count_nxt and no latch is inferred.
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + CW'(1);
    end else if (!push && pop) begin
      count_nxt = count - CW'(1);
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      almost_full <= 1'b0;
      push_drop   <= 1'b0;
    end else if (flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      almost_full <= 1'b0;
      if (in_valid) begin
        push_drop <= 1'b1;
      end
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count       <= count_nxt;
      almost_full <= (count_nxt >= AFULL_CNT);
    end
  end

  // NOTE: the storage array is deliberately not reset; valid data is tracked by
  // the reset control state, and leaving it unreset keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

endmodule

// File: tb/tb_param_input_buffer.sv
// Self-checking bench for param_input_buffer: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_param_input_buffer;

  localparam int W  = 131;
  localparam int D  = 32;
  localparam int AF = 28;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rstn;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [CW-1:0] count;
  logic          almost_full;
  logic          push_drop;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] model_q [$];
  bit           model_drop = 1'b0;

  always #5 clk = ~clk;

  param_input_buffer #(.WIDTH(W), .DEPTH(D), .AFULL_LVL(AF)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .count      (count),
    .almost_full(almost_full),
    .push_drop  (push_drop)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("count", W'(count), W'(model_q.size()));
    check("out_valid", W'(out_valid), W'(model_q.size() != 0));
    if (model_q.size() != 0) check("out_data", out_data, model_q[0]);
    check("almost_full", W'(almost_full), W'(model_q.size() >= AF));
    check("push_drop", W'(push_drop), W'(model_drop));
  endtask

  // One clock cycle: drive inputs, check ready, advance the model, check outputs.
  task automatic cycle(input bit v, input logic [W-1:0] d, input bit r, input bit f, input bit rs);
    bit do_pop;
    bit do_push;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    rstn      = rs;
    #1;
    check("in_ready", W'(in_ready), W'((model_q.size() != D) && !f));
    if (!rs) begin
      model_q.delete();
      model_drop = 1'b0;
    end else if (f) begin
      if (v) model_drop = 1'b1;
      model_q.delete();
    end else begin
      do_pop  = r && (model_q.size() != 0);
      do_push = v && (model_q.size() < D);
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back(d);
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [W-1:0] rand_data();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[W-1:0];
  endfunction

  initial begin
    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;

    // Reset state and in_ready right after release
    do_reset();
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("ready_after_reset", W'(in_ready), W'(1));

    // Latency: one edge from push to head
    cycle(1'b1, W'(131'h1_DEAD_BEEF), 1'b0, 1'b0, 1'b1);
    check("latency_valid", W'(out_valid), W'(1));
    check("latency_data", out_data, W'(131'h1_DEAD_BEEF));

    // Fill 0..31 with no consumer, then a refused 33rd push
    do_reset();
    for (int i = 0; i < D; i++) begin
      cycle(1'b1, W'(i), 1'b0, 1'b0, 1'b1);
      check("fill_afull", W'(almost_full), W'(i + 1 >= AF));
    end
    check("fill_in_ready", W'(in_ready), W'(0));
    cycle(1'b1, W'(99), 1'b1, 1'b0, 1'b1);
    check("full_no_passthru", W'(count), W'(D - 1));

    // Drain from full in order
    do_reset();
    for (int i = 0; i < D; i++) cycle(1'b1, W'(i), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < D; i++) begin
      check("drain_order", out_data, W'(i));
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
    end
    check("drain_empty", W'(out_valid), W'(0));
    check("drain_count", W'(count), W'(0));

    // Streaming across pointer wrap with 5 resident packets
    for (int i = 0; i < 5; i++) cycle(1'b1, W'(1000 + i), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 100; i++) begin
      check("stream_order", out_data, W'(1000 + i));
      cycle(1'b1, W'(1005 + i), 1'b1, 1'b0, 1'b1);
      check("stream_count", W'(count), W'(5));
    end

    // Flush with a push presented: sticky push_drop
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1'b1, rand_data(), 1'b0, 1'b0, 1'b1);
    cycle(1'b1, rand_data(), 1'b1, 1'b1, 1'b1);
    check("flush_count", W'(count), W'(0));
    check("flush_drop", W'(push_drop), W'(1));
    for (int i = 0; i < 50; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("drop_sticky", W'(push_drop), W'(1));

    // Mid-operation reset with 17 stored
    for (int i = 0; i < 17; i++) cycle(1'b1, rand_data(), 1'b0, 1'b0, 1'b1);
    cycle(1'b1, rand_data(), 1'b1, 1'b1, 1'b0);
    check("rst_count", W'(count), W'(0));
    check("rst_drop", W'(push_drop), W'(0));
    cycle(1'b1, W'(16'hABCD), 1'b0, 1'b0, 1'b1);
    check("rst_first_read", out_data, W'(16'hABCD));

    // Randomized traffic with varying pressure, rare flush and reset
    for (int seg = 0; seg < 15; seg++) begin
      int p_in;
      int p_out;
      p_in  = $urandom_range(10, 95);
      p_out = $urandom_range(10, 95);
      for (int i = 0; i < 200; i++) begin
        cycle($urandom_range(0, 99) < p_in, rand_data(), $urandom_range(0, 99) < p_out,
              $urandom_range(0, 149) == 0, $urandom_range(0, 399) != 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
